elevator_car_ctrl: RTL and testbench

Parametrised elevator car controller for an N-floor shaft. It latches floor requests into an internal pending mask and serves them in SCAN order, reversing direction only when nothing remains ahead. It times travel and door dwell from an internal tick divider and returns the car to a programmable home floor when idle. It sits between the request/queue logic and the car display/motor drivers and replaces the fixed 8-floor car model.

---
 rtl/elevator_car_ctrl.sv | 173 +++++++++++++++++
 tb/tb_elevator_car_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/elevator_car_ctrl.sv
// SCAN-order elevator car controller with tick-timed travel/dwell and home-floor parking.
// Optional `ELEVATOR_DOOR_HOLD_EN adds a door_hold input that keeps the door open.
module elevator_car_ctrl #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = $clog2(NUM_FLOORS),
  parameter int TICK_DIV    = 1000000,
  parameter int DOOR_TICKS  = 2,
  parameter int RESET_FLOOR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef ELEVATOR_DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  input  logic [FLOOR_W-1:0]    default_floor,
  input  logic [NUM_FLOORS-1:0] req_vec,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  current_up_ndown,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrive,
  output logic                  busy
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DOOR_TICKS + 1);
  localparam logic [TW-1:0]      TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0]      DWELL_INIT = DW'(DOOR_TICKS);
  localparam logic [FLOOR_W-1:0] TOP        = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] RST_FL     = FLOOR_W'(RESET_FLOOR);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_MOVE = 3'd2;
  localparam logic [2:0] S_DOOR = 3'd3;
  localparam logic [2:0] S_RET  = 3'd4;

  logic [2:0]            state, state_nxt;
  logic [TW-1:0]         tick_cnt;
  logic                  tick;
  logic [DW-1:0]         dwell, dwell_nxt;
  logic [FLOOR_W-1:0]    cf_nxt, home;
  logic                  dir_nxt;
  logic [NUM_FLOORS-1:0] pend_nxt, clr;
  logic                  ahead_up, ahead_dn, at_req, hold_rel;

  function automatic logic [FLOOR_W-1:0] step(input logic [FLOOR_W-1:0] f, input logic up);
    if (up) return (f == TOP) ? f : f + FLOOR_W'(1);
    else    return (f == '0)  ? f : f - FLOOR_W'(1);
  endfunction

  assign tick = (tick_cnt == TICK_LAST);
  assign home = (int'(default_floor) > NUM_FLOORS - 1) ? TOP : default_floor;
  assign at_req = pending[current_floor];

`ifdef ELEVATOR_DOOR_HOLD_EN
  // Holding the door or re-requesting the open floor restarts the dwell.
  assign hold_rel = door_hold | req_vec[current_floor];
`else
  assign hold_rel = 1'b0;
`endif

  always_comb begin
    ahead_up = 1'b0;
    ahead_dn = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(current_floor)) ahead_up = ahead_up | pending[i];
      if (i < int'(current_floor)) ahead_dn = ahead_dn | pending[i];
    end
  end

  always_comb begin
    state_nxt = state;
    cf_nxt    = current_floor;
    dir_nxt   = current_up_ndown;
    dwell_nxt = dwell;
    case (state)
      S_IDLE: begin
        if (at_req) begin
          if (tick) state_nxt = S_DOOR;
        end else if (|pending) begin
          if (tick) state_nxt = S_PREP;
        end else if (current_floor != home) begin
          state_nxt = S_RET;
          dir_nxt   = (home > current_floor);
        end
      end
      S_PREP: begin
        // Keep heading while work remains ahead; otherwise turn toward what is left.
        if (!(current_up_ndown && ahead_up) && !(!current_up_ndown && ahead_dn)) begin
          if (ahead_up)      dir_nxt = 1'b1;
          else if (ahead_dn) dir_nxt = 1'b0;
        end
        if (pending == '0) state_nxt = S_IDLE;
        else if (at_req)   state_nxt = S_DOOR;
        else               state_nxt = S_MOVE;
      end
      S_MOVE: begin
        if (tick) begin
          cf_nxt = step(current_floor, current_up_ndown);
          if (pending[cf_nxt]) state_nxt = S_DOOR;
          else if (!(current_up_ndown ? ahead_up : ahead_dn)) state_nxt = S_PREP;
        end
      end
      S_DOOR: begin
        if (hold_rel) begin
          dwell_nxt = DWELL_INIT;
        end else if (tick) begin
          if (dwell <= DW'(1)) begin
            dwell_nxt = '0;
            if (|pending) state_nxt = S_PREP;
            else if (current_floor == home) state_nxt = S_IDLE;
            else begin
              state_nxt = S_RET;
              dir_nxt   = (home > current_floor);
            end
          end else begin
            dwell_nxt = dwell - DW'(1);
          end
        end
      end
      S_RET: begin
        if (tick) begin
          if (|pending) state_nxt = S_PREP;
          else if (current_floor == home) state_nxt = S_IDLE;
          else begin
            dir_nxt = (home > current_floor);
            cf_nxt  = step(current_floor, home > current_floor);
            if (cf_nxt == home) state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt == S_DOOR && state != S_DOOR) dwell_nxt = DWELL_INIT;
  end

  // The floor being served is cleared from the cycle the door opens until it closes.
  always_comb begin
    clr = '0;
    if (state == S_DOOR || state_nxt == S_DOOR)
      clr = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << cf_nxt;
    pend_nxt = (pending | req_vec) & ~clr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt         <= '0;
      state            <= S_IDLE;
      current_floor    <= RST_FL;
      current_up_ndown <= 1'b0;
      pending          <= '0;
      dwell            <= '0;
      arrive           <= 1'b0;
    end else begin
      tick_cnt         <= tick ? '0 : tick_cnt + TW'(1);
      state            <= state_nxt;
      current_floor    <= cf_nxt;
      current_up_ndown <= dir_nxt;
      pending          <= pend_nxt;
      dwell            <= dwell_nxt;
      arrive           <= (state_nxt == S_DOOR) && (state != S_DOOR);
    end
  end

  assign moving    = (state == S_MOVE) || (state == S_RET);
  assign door_open = (state == S_DOOR);
  assign busy      = (state != S_IDLE);

  assert property (@(posedge clk) disable iff (!reset) int'(current_floor) < NUM_FLOORS);

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl: 8 floors, TICK_DIV=4, DOOR_TICKS=2.
// Status word st = {busy, moving, door_open, arrive, current_up_ndown}; E<n> = posedge n after reset release.
module tb_elevator_car_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] default_floor;
  logic [7:0] req_vec;
  logic [7:0] pending;
  logic [2:0] current_floor;
  logic       current_up_ndown, moving, door_open, arrive, busy;
`ifdef ELEVATOR_DOOR_HOLD_EN
  logic       door_hold = 1'b0;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elevator_car_ctrl #(
    .NUM_FLOORS(8), .TICK_DIV(4), .DOOR_TICKS(2), .RESET_FLOOR(0)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef ELEVATOR_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .default_floor(default_floor),
    .req_vec(req_vec),
    .pending(pending),
    .current_floor(current_floor),
    .current_up_ndown(current_up_ndown),
    .moving(moving),
    .door_open(door_open),
    .arrive(arrive),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] st();
    return 32'({busy, moving, door_open, arrive, current_up_ndown});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    default_floor = 3'd3;
    req_vec       = 8'h00;
    #12;
    chk("rst_floor", 32'(current_floor), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_status", st(), 'b00000);
    reset = 1'b1;

    // Park from 0 to home floor 3
    cyc(1);  chk("park_e1_st", st(), 'b11001);
    chk("park_e1_fl", 32'(current_floor), 0);
    cyc(3);  chk("park_e4_fl", 32'(current_floor), 1);
    cyc(4);  chk("park_e8_fl", 32'(current_floor), 2);
    chk("park_e8_st", st(), 'b11001);
    cyc(4);  chk("park_e12_fl", 32'(current_floor), 3);
    chk("park_e12_st", st(), 'b00001);

    // Request at parked floor
    req_vec = 8'h08;
    cyc(1);  chk("here_e13_pend", 32'(pending), 'h08);
    chk("here_e13_st", st(), 'b00001);
    req_vec = 8'h00;
    cyc(3);  chk("here_e16_st", st(), 'b10111);
    chk("here_e16_pend", 32'(pending), 0);
    cyc(1);  chk("here_e17_st", st(), 'b10101);
    req_vec = 8'h08;
    cyc(1);  chk("here_absorb_pend", 32'(pending), 0);
    req_vec = 8'h00;
    cyc(5);  chk("here_e23_st", st(), 'b10101);
    cyc(1);  chk("here_e24_st", st(), 'b00001);

    // Scan 5, 7, then reverse to 1
    req_vec = 8'hA2;
    cyc(1);  chk("scan_e25_pend", 32'(pending), 'hA2);
    req_vec = 8'h00;
    cyc(11); chk("scan_e36_fl", 32'(current_floor), 5);
    chk("scan_e36_st", st(), 'b10111);
    chk("scan_e36_pend", 32'(pending), 'h82);
    cyc(16); chk("scan_e52_fl", 32'(current_floor), 7);
    chk("scan_e52_st", st(), 'b10111);
    chk("scan_e52_pend", 32'(pending), 'h02);
    cyc(7);  chk("scan_e59_st", st(), 'b10101);
    cyc(1);  chk("scan_e60_prep", st(), 'b10001);
    cyc(1);  chk("scan_e61_rev", st(), 'b11000);
    chk("scan_e61_fl", 32'(current_floor), 7);
    cyc(23); chk("scan_e84_fl", 32'(current_floor), 1);
    chk("scan_e84_st", st(), 'b10110);
    chk("scan_e84_pend", 32'(pending), 0);
    cyc(8);  chk("scan_e92_ret", st(), 'b11001);
    cyc(8);  chk("scan_e100_fl", 32'(current_floor), 3);
    chk("scan_e100_st", st(), 'b00001);

    // Return abort: go to 6, home becomes 0, request 7 while passing 4
    req_vec = 8'h40;
    cyc(1);  req_vec = 8'h00;
    cyc(15); chk("abort_e116_fl", 32'(current_floor), 6);
    chk("abort_e116_st", st(), 'b10111);
    default_floor = 3'd0;
    cyc(8);  chk("abort_e124_st", st(), 'b11000);
    cyc(8);  chk("abort_e132_fl", 32'(current_floor), 4);
    req_vec = 8'h80;
    cyc(1);  chk("abort_e133_pend", 32'(pending), 'h80);
    req_vec = 8'h00;
    cyc(3);  chk("abort_e136_st", st(), 'b10000);
    chk("abort_e136_fl", 32'(current_floor), 4);
    cyc(1);  chk("abort_e137_st", st(), 'b11001);
    cyc(11); chk("abort_e148_fl", 32'(current_floor), 7);
    chk("abort_e148_st", st(), 'b10111);
    chk("abort_e148_pend", 32'(pending), 0);
    cyc(8);  chk("abort_e156_st", st(), 'b11000);
    cyc(28); chk("abort_e184_fl", 32'(current_floor), 0);
    chk("abort_e184_st", st(), 'b00000);

    // Async reset while moving
    req_vec = 8'h20;
    cyc(1);  req_vec = 8'h00;
    cyc(11); chk("arst_e196_fl", 32'(current_floor), 2);
    chk("arst_e196_st", st(), 'b11001);
    #3 reset = 1'b0;
    #1 chk("arst_fl", 32'(current_floor), 0);
    chk("arst_pend", 32'(pending), 0);
    chk("arst_st", st(), 'b00000);
    #2 reset = 1'b1;
    cyc(2);  chk("arst_after_st", st(), 'b00000);

`ifdef ELEVATOR_DOOR_HOLD_EN
    // Door hold for 5 ticks at floor 0
    req_vec = 8'h01;
    cyc(1);  req_vec = 8'h00;
    cyc(1);  chk("hold_e4_st", st(), 'b10110);
    door_hold = 1'b1;
    cyc(20); chk("hold_e24_st", st(), 'b10100);
    door_hold = 1'b0;
    cyc(7);  chk("hold_e31_st", st(), 'b10100);
    cyc(1);  chk("hold_e32_st", st(), 'b00000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
